// File: rtl/dpram_pkg.sv
// Shared constants and FSM encoding for the DPRAM burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_pkg;

    localparam int DPRAM_DEPTH_DEF = 8;
    localparam int DPRAM_WIDTH_DEF = 8;

    // Reader FSM: IDLE waits for a request, RUN issues reads, DRAIN empties the buffer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dpram.sv
// Simple true dual-port RAM, both ports synchronous read and write.
// Latency: read data valid one clock after the address is sampled.
// Backpressure: none; every port accepts an access each cycle.
module dpram #(
    parameter  int DEPTH  = 8,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [WIDTH-1:0]  a_din_i,
    output logic [WIDTH-1:0]  a_dout_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [WIDTH-1:0]  b_din_i,
    output logic [WIDTH-1:0]  b_dout_o
);

    logic [WIDTH-1:0] ram_q [DEPTH];

    // Both ports write and read the shared array; port B wins a same-address write.
    always_ff @(posedge clk_i) begin
        if (a_we_i) ram_q[a_addr_i] <= a_din_i;
        if (b_we_i) ram_q[b_addr_i] <= b_din_i;
        a_dout_o <= ram_q[a_addr_i];
        b_dout_o <= ram_q[b_addr_i];
    end

endmodule

// File: rtl/dpram_rd_fifo2.sv
// Two-entry output buffer holding returned read data for the stream port.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped only if full with no pop; the caller's credit check prevents that.
module dpram_rd_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] slot_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;
    assign head_dat = slot_q[rd_ptr_q];

    // A full buffer may still accept a push when the head leaves in the same cycle.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign wr_ptr_d = wr_ptr_q ^ do_push;
    assign rd_ptr_d = rd_ptr_q ^ do_pop;
    assign count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) slot_q[wr_ptr_q] <= push_dat;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dpram_burst_reader.sv
// Reads a burst of consecutive (wrapping) DPRAM words and streams them out valid/ready.
// Latency: request accepted at T, first read address at T+1, first beat valid at T+3.
// Backpressure: reads are credit-limited to the 2-entry buffer; out_ready low stalls issue, never drops data.
module dpram_burst_reader
    import dpram_pkg::*;
#(
    parameter  int DEPTH  = DPRAM_DEPTH_DEF,
    parameter  int WIDTH  = DPRAM_WIDTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_din,
    input  logic [WIDTH-1:0]  mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic              done_q, done_d;

    logic [LEN_W-1:0]  len_clamped;
    logic [WIDTH:0]    head_dat;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_count;
    logic              pop, head_last;
    logic [2:0]        credit_use;
    logic              credit_ok, issue;

    // Buffer entries carry the last-beat flag alongside the data word.
    dpram_rd_fifo2 #(.W(WIDTH + 1)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_vld_q),
        .push_dat ({rd_last_q, mem_dout}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign len_clamped = (req_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : req_len;

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : head_dat[WIDTH-1:0];
    assign out_last  = ~fifo_empty & head_dat[WIDTH];
    assign head_last = head_dat[WIDTH];
    assign pop       = out_valid & out_ready;

    // Buffered words plus the one read in flight, less the beat leaving now, must leave room.
    assign credit_use = {1'b0, fifo_count} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign credit_ok  = (credit_use < 3'd2) && !(fifo_full && !pop);
    assign issue      = (state_q == ST_RUN) && credit_ok;

    assign mem_we   = 1'b0;
    assign mem_din  = '0;
    assign mem_addr = addr_q;
    assign done     = done_q;

    // State and datapath registers; reset aborts any burst and discards a pending return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            done_q    <= done_d;
        end
    end

    // Next-state, read issue and handshake outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        done_d    = pop & head_last;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    addr_d = req_addr;
                    rem_d  = len_clamped;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rd_vld_d  = 1'b1;
                    rd_last_d = (rem_q == LEN_W'(1));
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dpram_burst_reader.sv
module tb_dpram_burst_reader;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [2:0] req_addr;
    logic [3:0] req_len;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_din, mem_dout;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       out_last, busy, done;
    logic       a_we;
    logic [2:0] a_addr;
    logic [7:0] a_din, a_dout;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] model_mem [DEPTH];
    logic [8:0] exp_q [$];
    logic       exp_done_next;
    logic       prev_stall;
    logic [8:0] prev_beat;
    logic       obs_valid;
    int         ready_mode;
    int         pat_idx;
    int         beats_seen;
    bit         stall_pat [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 1};

    always #5 clk = ~clk;

    dpram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk_i    (clk),
        .a_we_i   (a_we),
        .a_addr_i (a_addr),
        .a_din_i  (a_din),
        .a_dout_o (a_dout),
        .b_we_i   (mem_we),
        .b_addr_i (mem_addr),
        .b_din_i  (mem_din),
        .b_dout_o (mem_dout)
    );

    dpram_burst_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe registered outputs at the falling edge, then drive out_ready
    // and score the beat that the next rising edge will consume.
    task automatic tick();
        logic       hs;
        logic [8:0] e;
        @(negedge clk);
        obs_valid = out_valid;
        check_val("done", 32'(done), 32'(exp_done_next));
        exp_done_next = 1'b0;
        if (prev_stall) begin
            check_val("hold_vld", 32'(out_valid), 32'd1);
            check_val("hold_beat", 32'({out_last, out_data}), 32'(prev_beat));
        end
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (pat_idx < 10) ? stall_pat[pat_idx] : 1'b1;
                if (out_valid) pat_idx++;
            end
        endcase
        hs = out_valid & out_ready;
        if (hs) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                check_val("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("beat", 32'({out_last, out_data}), 32'(e));
                if (e[8]) exp_done_next = 1'b1;
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_beat  = {out_last, out_data};
    endtask

    task automatic expect_burst(input int a, input int eff);
        logic [8:0] e;
        for (int i = 0; i < eff; i++) begin
            e = {(i == eff - 1), model_mem[(a + i) % DEPTH]};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_burst(input int a, input int l, input int mode);
        int eff;
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check_val("idle_before_req", 32'(req_ready), 32'd1);
        eff = (l > DEPTH) ? DEPTH : l;
        expect_burst(a, eff);
        ready_mode = mode;
        pat_idx    = 0;
        req_valid  = 1'b1;
        req_addr   = a[2:0];
        req_len    = l[3:0];
        if (eff == 0) exp_done_next = 1'b1;
        tick();
        req_valid = 1'b0;
        if (eff > 0) begin
            check_val("busy_ready", 32'({busy, req_ready}), 32'd2);
            n = 1;
            while (!obs_valid && n < 10) begin
                tick();
                n++;
            end
            check_val("first_latency", 32'(n), 32'd3);
            if (mode == 0) begin
                repeat (eff - 1) tick();
                check_val("no_bubble", 32'(exp_q.size()), 32'd0);
            end
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check_val("beats_left", 32'(exp_q.size()), 32'd0);
        check_val("mem_we_din", 32'({mem_we, mem_din}), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b0;
        a_we = 1'b0; a_addr = '0; a_din = '0;
        exp_done_next = 1'b0; prev_stall = 1'b0; prev_beat = '0; obs_valid = 1'b0;
        ready_mode = 0; pat_idx = 0; beats_seen = 0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            a_we   = 1'b1;
            a_addr = 3'(i);
            a_din  = 8'hA0 + 8'(i);
            model_mem[i] = 8'hA0 + 8'(i);
        end
        @(negedge clk);
        a_we = 1'b0;

        tick();
        check_val("rst_outputs", 32'({out_valid, out_last, out_data, mem_addr, busy, mem_we, mem_din}), 32'd0);
        rst = 1'b0;
        tick();
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("post_rst_outputs", 32'({out_valid, out_last, out_data, mem_addr, busy}), 32'd0);

        run_burst(0, 8, 0);
        run_burst(6, 4, 0);
        run_burst(0, 8, 2);
        run_burst(0, 0, 0);
        run_burst(3, 1, 0);
        run_burst(2, 9, 0);

        // Abort a full burst on its third beat.
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        expect_burst(0, 8);
        ready_mode = 0;
        base       = beats_seen;
        req_valid  = 1'b1;
        req_addr   = 3'd0;
        req_len    = 4'd8;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (beats_seen < base + 3 && n < 50) begin
            tick();
            n++;
        end
        check_val("third_beat_seen", 32'(beats_seen - base), 32'd3);
        rst = 1'b1;
        exp_q.delete();
        exp_done_next = 1'b0;
        prev_stall    = 1'b0;
        tick();
        check_val("abort_outputs", 32'({out_valid, out_last, out_data, mem_addr, busy, mem_we, mem_din}), 32'd0);
        rst = 1'b0;
        tick();
        check_val("abort_ready", 32'(req_ready), 32'd1);
        check_val("abort_idle", 32'({out_valid, busy}), 32'd0);
        run_burst(5, 2, 0);

        repeat (12) begin
            run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), int'($urandom_range(0, 1)));
        end
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
